sub_bytes_ctrl: RTL and testbench

//  Sequencer for the SubBytes round step. Accepts a 128-bit AES state and streams it as

---
 rtl/sub_bytes_ctrl_if.sv | 49 ++++
 rtl/sub_bytes_ctrl.sv | 133 +++++++++++++
 tb/tb_sub_bytes_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_ctrl_if.sv
// Bundle of every signal between the SubBytes sequencer and its neighbours:
// the upstream state strobe, the shared sbox request/response port and the
// downstream ShiftRows result.
//
// Handshake semantics (single reference for all strobes on this bundle):
//   - state_in_vld is a 1-cycle start strobe. It is honoured only when sb_ready=1.
//     While sb_ready=0 it is dropped with no effect.
//   - sub_bytes_val_vld is a 1-cycle request strobe. It is issued only in a cycle
//     after sbox_available was seen high. It is never retracted or repeated,
//     except as a re-request after a response timeout.
//   - sub_bytes_sbox_data_vld is a 1-cycle response strobe. It is consumed only
//     while a request is outstanding and is ignored otherwise.
//   - state_out_vld is a 1-cycle result strobe with no back-pressure. state_out
//     keeps its value between strobes.
interface sub_bytes_ctrl_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
);
    localparam int STATE_W = WORD_W * NUM_WORDS;

    logic [STATE_W-1:0] state_in;
    logic               state_in_vld;
    logic               sb_ready;
    logic               sbox_available;
    logic [WORD_W-1:0]  sub_bytes_val;
    logic               sub_bytes_val_vld;
    logic [WORD_W-1:0]  sub_bytes_sbox_data;
    logic               sub_bytes_sbox_data_vld;
    logic [STATE_W-1:0] state_out;
    logic               state_out_vld;
    logic               sb_err;
    logic [1:0]         dbg_state;

    // master: the sequencer itself
    modport master (
        input  state_in, state_in_vld, sbox_available,
               sub_bytes_sbox_data, sub_bytes_sbox_data_vld,
        output sb_ready, sub_bytes_val, sub_bytes_val_vld,
               state_out, state_out_vld, sb_err, dbg_state
    );

    // slave: the environment (upstream, sbox_lut, ShiftRows)
    modport slave (
        output state_in, state_in_vld, sbox_available,
               sub_bytes_sbox_data, sub_bytes_sbox_data_vld,
        input  sb_ready, sub_bytes_val, sub_bytes_val_vld,
               state_out, state_out_vld, sb_err, dbg_state
    );
endinterface

// File: rtl/sub_bytes_ctrl.sv
// SubBytes sequencer.
// It takes a 128-bit AES state and sends it to the shared sbox_lut as four
// 32-bit words, most significant word first. It reassembles the substituted
// words in the same byte order and then raises a single result strobe.
// It uses the sbox only when sbox_available says key expansion is not using it.
// A missing response is re-requested after TIMEOUT cycles, and sticky sb_err
// records that this happened.
module sub_bytes_ctrl #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    sub_bytes_ctrl_if.master bus
);
    localparam int STATE_W = WORD_W * NUM_WORDS;
    localparam int LSB_W   = $clog2(STATE_W);

    localparam logic [1:0] LAST_WORD    = 2'(NUM_WORDS - 1);
    localparam logic [3:0] TIMEOUT_CNT  = 4'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [STATE_W-1:0] in_q, in_d;
    logic [WORD_W-1:0]  val_q, val_d;
    logic               val_vld_q, val_vld_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic               err_q, err_d;

    logic [LSB_W-1:0]   word_lsb;
    logic [3:0]         wait_inc;

    // Word 0 sits at the top of the state, so the bit offset counts down as cnt rises
    assign word_lsb = LSB_W'((NUM_WORDS - 1 - int'(cnt_q)) * WORD_W);
    assign wait_inc = wait_cnt_q + 4'd1;

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_cnt_d = wait_cnt_q;
        in_d       = in_q;
        val_d      = val_q;
        val_vld_d  = 1'b0;
        out_d      = out_q;
        out_vld_d  = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.state_in_vld) begin
                    in_d    = bus.state_in;
                    cnt_d   = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Key expansion owns the sbox while sbox_available is low
                if (bus.sbox_available) begin
                    val_d      = in_q[word_lsb +: WORD_W];
                    val_vld_d  = 1'b1;
                    wait_cnt_d = 4'd0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A response takes priority over a timeout in the same cycle
                if (bus.sub_bytes_sbox_data_vld) begin
                    out_d[word_lsb +: WORD_W] = bus.sub_bytes_sbox_data;
                    if (cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                out_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            wait_cnt_q <= 4'd0;
            in_q       <= '0;
            val_q      <= '0;
            val_vld_q  <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            in_q       <= in_d;
            val_q      <= val_d;
            val_vld_q  <= val_vld_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            err_q      <= err_d;
        end
    end

    assign bus.sb_ready          = (state_q == IDLE);
    assign bus.sub_bytes_val     = val_q;
    assign bus.sub_bytes_val_vld = val_vld_q;
    assign bus.state_out         = out_q;
    assign bus.state_out_vld     = out_vld_q;
    assign bus.sb_err            = err_q;
    assign bus.dbg_state         = state_q;
endmodule

// File: tb/tb_sub_bytes_ctrl.sv
// Bench for sub_bytes_ctrl.
// A behavioural sbox_lut with programmable latency answers the requests. The
// expected state is computed from an AES S-box that the bench builds from
// GF(2^8) inversion plus the affine map. A request log checks the order of
// issued words.
module tb_sub_bytes_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sub_bytes_ctrl_if bus ();

    sub_bytes_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Inputs owned by the main thread
    logic [127:0] st_in   = '0;
    logic         st_vld  = 1'b0;
    logic         avail   = 1'b1;
    // Inputs owned by the sbox model
    logic [31:0]  resp_d  = '0;
    logic         resp_v  = 1'b0;

    assign bus.state_in                = st_in;
    assign bus.state_in_vld            = st_vld;
    assign bus.sbox_available          = avail;
    assign bus.sub_bytes_sbox_data     = resp_d;
    assign bus.sub_bytes_sbox_data_vld = resp_v;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference S-box ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv;
            r = inv;
            for (int k = 0; k < 4; k++) begin
                r = rotl1(r);
                s = s ^ r;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sbox_t[w[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_t[s[i*8 +: 8]];
        return r;
    endfunction

    // ---------------- sbox_lut model ----------------
    int          lat      = 1;    // extra cycles between request and response
    int          drop_at  = -1;   // absolute request index whose response is withheld
    int          req_total = 0;
    logic [31:0] req_log [$];
    int          pend_t [$];
    logic [31:0] pend_d [$];

    always @(negedge clk) begin
        resp_v = 1'b0;
        if (!reset) begin
            pend_t.delete();
            pend_d.delete();
        end else begin
            if (bus.sub_bytes_val_vld) begin
                req_log.push_back(bus.sub_bytes_val);
                if (req_total != drop_at) begin
                    pend_t.push_back(cyc + lat);
                    pend_d.push_back(sub_word(bus.sub_bytes_val));
                end
                req_total++;
            end
            if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                resp_v = 1'b1;
                resp_d = pend_d.pop_front();
                void'(pend_t.pop_front());
            end
        end
    end

    // ---------------- driver: one SubBytes operation ----------------
    // hold: cycles sbox_available is held low after the start strobe
    // mid: inject a stray zero-state strobe while busy
    // drop_rel: request index within this op whose response is withheld (-1 none)
    // exp_lat: expected start-to-result latency without hold (-1 skips the check)
    task automatic run_op(input string tag, input logic [127:0] st, input int hold,
                          input bit mid, input bit rnd_avail, input int drop_rel,
                          input int exp_lat);
        int base, lat_obs, pulses, nreq;
        bit seen, hold_clean;
        logic [127:0] got;
        logic [31:0] exp_w [$];
        @(negedge clk);
        base    = req_total;
        drop_at = (drop_rel >= 0) ? base + drop_rel : -1;
        st_in   = st;
        st_vld  = 1'b1;
        avail   = (hold > 0) ? 1'b0 : 1'b1;
        seen = 1'b0; lat_obs = -1; pulses = 0; hold_clean = 1'b1; got = '0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (k == 1) st_vld = 1'b0;
            if (mid && k == 5) begin st_in = '0; st_vld = 1'b1; end
            if (mid && k == 6) st_vld = 1'b0;
            if (hold > 0) avail = (k > hold);
            else if (rnd_avail) avail = ($urandom_range(0, 3) != 0);
            else avail = 1'b1;
            if (k <= hold && bus.sub_bytes_val_vld) hold_clean = 1'b0;
            if (k == 2) check({tag, " busy_ready"}, bus.sb_ready, 1'b0);
            if (bus.state_out_vld) begin
                pulses++;
                if (!seen) begin
                    seen    = 1'b1;
                    lat_obs = k;
                    got     = bus.state_out;
                end
            end
            if (seen && k >= lat_obs + 8) break;
        end
        avail   = 1'b1;
        drop_at = -1;
        check({tag, " done_seen"}, seen, 1'b1);
        check({tag, " out_pulses"}, pulses, 1);
        check({tag, " state_out"}, got, ref_sub(st));
        check({tag, " ready_after"}, bus.sb_ready, 1'b1);
        if (hold > 0) check({tag, " no_req_in_hold"}, hold_clean, 1'b1);
        if (exp_lat >= 0) check({tag, " latency"}, lat_obs, exp_lat + hold);
        for (int i = 0; i < 4; i++) begin
            exp_w.push_back(st[127 - 32*i -: 32]);
            if (i == drop_rel) exp_w.push_back(st[127 - 32*i -: 32]);
        end
        nreq = req_total - base;
        check({tag, " req_count"}, nreq, exp_w.size());
        for (int i = 0; i < exp_w.size() && i < nreq; i++)
            check($sformatf("%s req%0d", tag, i), req_log[base + i], exp_w[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sb_ready"}, bus.sb_ready, 1'b1);
        check({tag, " val"}, bus.sub_bytes_val, 32'h0);
        check({tag, " val_vld"}, bus.sub_bytes_val_vld, 1'b0);
        check({tag, " state_out"}, bus.state_out, 128'h0);
        check({tag, " out_vld"}, bus.state_out_vld, 1'b0);
        check({tag, " sb_err"}, bus.sb_err, 1'b0);
        check({tag, " fsm"}, bus.dbg_state, 2'd0);
    endtask

    // ---------------- main sequence ----------------
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        logic [127:0] rs;
        int base;
        bit reached;
        build_sbox();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // FIPS-197 round 1 vector, fixed sbox latency of 1
        lat = 1;
        run_op("fips", FIPS_IN, 0, 1'b0, 1'b0, -1, 2 + 4 * (2 + 1));
        check("fips const", bus.state_out, FIPS_OUT);
        check("fips err", bus.sb_err, 1'b0);

        // Uniform states
        run_op("zeros", 128'h0, 0, 1'b0, 1'b0, -1, 2 + 4 * 3);
        check("zeros const", bus.state_out, {16{8'h63}});
        lat = 0;
        run_op("ones", {128{1'b1}}, 0, 1'b0, 1'b0, -1, 2 + 4 * 2);
        check("ones const", bus.state_out, {16{8'h16}});

        // Key expansion holds the sbox for 10 cycles
        lat = 2;
        run_op("hold", FIPS_IN, 10, 1'b0, 1'b0, -1, 2 + 4 * (2 + 2));

        // Stray start strobe while busy
        lat = 1;
        run_op("mid_strobe", FIPS_IN, 0, 1'b1, 1'b0, -1, 2 + 4 * 3);

        // Randomised states, latencies and sbox availability
        for (int n = 0; n < 16; n++) begin
            rs  = {$urandom, $urandom, $urandom, $urandom};
            lat = $urandom_range(0, 3);
            if (n % 2 == 0)
                run_op($sformatf("rand%0d", n), rs, 0, 1'b0, 1'b0, -1, 2 + 4 * (2 + lat));
            else
                run_op($sformatf("rand%0d", n), rs, 0, 1'b0, 1'b1, -1, -1);
            check($sformatf("rand%0d err", n), bus.sb_err, 1'b0);
        end

        // Withheld response for word 2: timeout, re-issue, sticky error
        lat = 1;
        rs  = {$urandom, $urandom, $urandom, $urandom};
        run_op("timeout", rs, 0, 1'b0, 1'b0, 2, -1);
        check("timeout err", bus.sb_err, 1'b1);
        run_op("after_timeout", FIPS_IN, 0, 1'b0, 1'b0, -1, 2 + 4 * 3);
        check("err sticky", bus.sb_err, 1'b1);

        // Reset while waiting on word 1
        lat = 3;
        @(negedge clk);
        base   = req_total;
        st_in  = FIPS_IN;
        st_vld = 1'b1;
        @(negedge clk);
        st_vld  = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (req_total >= base + 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_mid reached_wait1", reached, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.state_out_vld || bus.sub_bytes_val_vld) reached = 1'b1;
        end
        check("rst_mid quiet", reached, 1'b0);
        reset = 1'b1;
        run_op("post_reset", FIPS_IN, 0, 1'b0, 1'b0, -1, 2 + 4 * (2 + 3));
        check("post_reset const", bus.state_out, FIPS_OUT);
        check("post_reset err", bus.sb_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
